// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, parameterised ALU sitting between issue and writeback.
//
// Accepts one operation per valid/ready transfer. ADD/SUB/SLT/AND/OR/XOR/SHIFT
// complete in one cycle. MUL runs an iterative shift-add engine, one multiplier
// bit per clock. Each result and its flags stay in an output register until the
// consumer takes them, so a stalled writeback never loses a result.
//
// Vectors are declared [0:WIDTH-1]: bit 0 is the MSB (sign bit).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   in_valid   operation offered this cycle
//   in_ready   block can accept an operation this cycle
//   op         opcode (ALU_* encodings below)
//   in1, in2   operands A and B
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result this cycle
//   out        result
//   zero       out == 0
//   carry      ADD carry-out / SUB borrow, 0 otherwise
//   overflow   signed overflow (ADD/SUB), non-zero high half (MUL), 0 otherwise

module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [0:WIDTH-1] in1,
    input  logic [0:WIDTH-1] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    // Opcode encodings shared with the decode stage.
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_SLT   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_XOR   = 3'd5;
    localparam logic [2:0] ALU_SHIFT = 3'd6;
    localparam logic [2:0] ALU_MUL   = 3'd7;

    localparam logic [WIDTH:0]   SH_LIMIT  = (WIDTH+1)'(WIDTH);
    localparam logic [CNT_W-1:0] MUL_STEPS = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StMulBusy,
        StFull
    } state_e;

    state_e state_q, state_d;

    logic accept;
    logic consume;
    logic mul_done;

    // Multiply engine
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [0:WIDTH-1]   mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Output register
    logic [0:WIDTH-1] out_q, out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    // Single-cycle datapath
    logic [WIDTH:0]        add_full;
    logic [WIDTH:0]        sub_full;
    logic signed [WIDTH:0] shamt_s;
    logic [WIDTH:0]        shmag;
    logic [0:WIDTH-1]      alu_res;
    logic                  alu_c;
    logic                  alu_v;

    //--------------------------------------------------------------------------
    // Handshake
    //--------------------------------------------------------------------------
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign mul_done = (state_q == StMulBusy) && (cnt_q == CNT_LAST);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (op == ALU_MUL) ? StMulBusy : StFull;
                end
            end
            StMulBusy: begin
                if (mul_done) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // A new accept overrides the plain consume.
                if (accept) begin
                    state_d = (op == ALU_MUL) ? StMulBusy : StFull;
                end else if (consume) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StFull) && out_ready);
        out_valid = (state_q == StFull);
    end

    //--------------------------------------------------------------------------
    // Single-cycle ALU
    //--------------------------------------------------------------------------
    always_comb begin
        add_full = {1'b0, in1} + {1'b0, in2};
        sub_full = {1'b0, in1} - {1'b0, in2};
        // in2 is a signed shift amount; widen by one bit so |most-negative| fits.
        shamt_s  = $signed({in2[0], in2});
        shmag    = shamt_s[WIDTH] ? $unsigned(-shamt_s) : $unsigned(shamt_s);

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (in1[0] == in2[0]) && (add_full[WIDTH-1] != in1[0]);
            end
            ALU_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];  // borrow: in1 < in2 unsigned
                alu_v   = (in1[0] != in2[0]) && (sub_full[WIDTH-1] != in1[0]);
            end
            ALU_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            end
            ALU_AND: alu_res = in1 & in2;
            ALU_OR:  alu_res = in1 | in2;
            ALU_XOR: alu_res = in1 ^ in2;
            ALU_SHIFT: begin
                if (shmag >= SH_LIMIT) begin
                    alu_res = '0;
                end else if (shamt_s[WIDTH]) begin
                    alu_res = in1 >> shmag;
                end else begin
                    alu_res = in1 << shmag;
                end
            end
            default: alu_res = '0;  // MUL is handled by the iterative engine
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath next state
    //--------------------------------------------------------------------------
    assign acc_step = acc_q + (mplr_q[WIDTH-1] ? mcand_q : '0);

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        if (accept) begin
            if (op == ALU_MUL) begin
                // Output register keeps its old contents; out_valid drops via state.
                mcand_d = {{WIDTH{1'b0}}, in1};
                mplr_d  = in2;
                acc_d   = '0;
                cnt_d   = MUL_STEPS;
            end else begin
                out_d   = alu_res;
                zero_d  = (alu_res == '0);
                carry_d = alu_c;
                ovf_d   = alu_v;
            end
        end else if (state_q == StMulBusy) begin
            acc_d   = acc_step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
                out_d   = acc_step[WIDTH-1:0];
                zero_d  = (acc_step[WIDTH-1:0] == '0);
                carry_d = 1'b0;
                ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out      = out_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=16 and WIDTH=8 instances).
// Expected results come from an arithmetic reference model and are queued at
// accept time; monitors pop and compare on every output transfer.

module tb_alu_pipe;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SLT   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_SHIFT = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic        in_valid, in_ready, out_valid, out_ready, zero, carry, overflow;
    logic [2:0]  op;
    logic [0:15] in1, in2, out;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, carry8, overflow8;
    logic [2:0]  op8;
    logic [0:7]  in1_8, in2_8, out8;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q16[$];
    exp_t q8[$];
    bit   rnd_en = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .CNT_W(5)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zero(zero), .carry(carry), .overflow(overflow)
    );

    alu_pipe #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .in1(in1_8), .in2(in2_8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .zero(zero8), .carry(carry8), .overflow(overflow8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on a w-bit word.
    function automatic exp_t model(input int w, input logic [2:0] o,
                                   input logic [15:0] a_in, input logic [15:0] b_in);
        longint unsigned mask, a, b, r, p, half;
        longint          sa, sb, s, hi, lo;
        exp_t            e;
        mask = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = (a >= half) ? longint'(a) - longint'(mask + 1) : longint'(a);
        sb   = (b >= half) ? longint'(b) - longint'(mask + 1) : longint'(b);
        hi   = longint'(half) - 1;
        lo   = -longint'(half);
        e.c  = 1'b0;
        e.v  = 1'b0;
        r    = 0;
        case (o)
            OP_ADD: begin
                r   = a + b;
                e.c = (r > mask);
                r   = r & mask;
                s   = sa + sb;
                e.v = (s > hi) || (s < lo);
            end
            OP_SUB: begin
                r   = (a - b) & mask;
                e.c = (a < b);
                s   = sa - sb;
                e.v = (s > hi) || (s < lo);
            end
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHIFT: begin
                if (sb >= w || sb <= -w) r = 0;
                else if (sb >= 0)        r = (a << sb) & mask;
                else                     r = a >> (-sb);
            end
            default: begin
                p   = a * b;
                r   = p & mask;
                e.v = ((p >> w) != 0);
            end
        endcase
        e.res = r[15:0];
        e.z   = (r == 0);
        return e;
    endfunction

    function automatic logic [15:0] rnd_opnd(input int w);
        logic [15:0] v;
        logic [15:0] m;
        m = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 5))
            0:       v = 16'h0000;
            1:       v = 16'hFFFF;
            2:       v = 16'(32'd1 << (w - 1));
            3:       v = 16'((32'd1 << (w - 1)) - 1);
            4:       v = 16'($urandom_range(0, 20));
            default: v = 16'($urandom);
        endcase
        return v & m;
    endfunction

    // Offer one op to the 16-bit DUT; returns after the accept edge (+1).
    task automatic issue16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                           input bit push, output int waited);
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) break;
        end
        if (waited > 100) begin
            chk("w16_issue_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            if (push) q16.push_back(model(16, o, a, b));
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int waited);
        in_valid8 = 1'b1;
        op8       = o;
        in1_8     = a[7:0];
        in2_8     = b[7:0];
        waited    = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready8) break;
            waited++;
            if (waited > 100) break;
        end
        if (waited > 100) begin
            chk("w8_issue_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            q8.push_back(model(8, o, a, b));
        end
        #1;
        in_valid8 = 1'b0;
    endtask

    // Monitors: compare on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                chk("w16_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                chk("w16_result{out,z,c,v}", {13'd0, out, zero, carry, overflow},
                    {13'd0, e.res, e.z, e.c, e.v});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("w8_result{out,z,c,v}", {21'd0, out8, zero8, carry8, overflow8},
                    {21'd0, e.res[7:0], e.z, e.c, e.v});
            end
        end
    end

    // Random backpressure on the 16-bit consumer.
    initial begin
        forever begin
            @(posedge clk);
            if (rnd_en) begin
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0]  sw_op [13];
    logic [15:0] sw_a  [13];
    logic [15:0] sw_b  [13];

    initial begin
        int          w;
        int          cnt;
        int          viol;
        logic [2:0]  o;
        logic [15:0] a;
        logic [15:0] b;

        sw_op = '{OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_SHIFT,
                  OP_SHIFT, OP_SHIFT, OP_ADD, OP_ADD, OP_SUB, OP_SLT};
        sw_a  = '{16'd5, 16'd15, 16'd5, 16'd9, 16'd9, 16'd9, 16'd5,
                  16'd40, 16'd1, 16'hFFFF, 16'h7FFF, 16'd4, 16'hFFFF};
        sw_b  = '{16'd7, 16'd4, 16'd7, 16'd12, 16'd12, 16'd12, 16'd3,
                  16'hFFFD, 16'd16, 16'd1, 16'd1, 16'd15, 16'd1};

        reset = 1'b1;
        in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; op8 = '0; in1_8 = '0; in2_8 = '0; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_flags", {zero, carry, overflow}, 0);
        chk("rst_w8_out_valid", out_valid8, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Directed sweep and flag edges, one op per cycle.
        for (int i = 0; i < 13; i++) begin
            issue16(sw_op[i], sw_a[i], sw_b[i], 1'b1, w);
            chk("sweep_no_stall", w, 0);
            chk("sweep_latency1_valid", out_valid, 1);
        end

        // MUL latency: result exactly 16 edges after accept, in_ready low meanwhile.
        issue16(OP_MUL, 16'd4, 16'd9, 1'b1, w);
        cnt  = 0;
        viol = 0;
        while (1) begin
            if (in_ready) viol++;
            @(posedge clk);
            #1;
            cnt++;
            if (out_valid || cnt >= 40) break;
        end
        chk("mul_latency", cnt, 16);
        chk("mul_in_ready_low", viol, 0);
        issue16(OP_MUL, 16'h0100, 16'h0100, 1'b1, w);
        repeat (20) @(posedge clk);
        #1;

        // Backpressure: result held, second op refused until out_ready rises.
        out_ready = 1'b0;
        issue16(OP_ADD, 16'd5, 16'd7, 1'b1, w);
        in_valid = 1'b1; op = OP_ADD; in1 = 16'd1; in2 = 16'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_out", out, 12);
            chk("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue16(OP_ADD, 16'd1, 16'd2, 1'b1, w);
        chk("bp_same_edge_accept", w, 0);
        chk("bp_next_result", {out_valid, out}, {1'b1, 16'd3});

        // Reset in the middle of a multiply: no result may emerge.
        issue16(OP_MUL, 16'd4, 16'd9, 1'b0, w);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out", out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready, 1);
        issue16(OP_ADD, 16'd1, 16'd1, 1'b1, w);
        repeat (25) @(posedge clk);
        #1;

        // Randomised traffic with random backpressure.
        rnd_en = 1'b1;
        repeat (300) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_opnd(16);
            if (o == OP_SHIFT && $urandom_range(0, 1) == 1) b = 16'(int'($urandom_range(0, 40)) - 20);
            else b = rnd_opnd(16);
            issue16(o, a, b, 1'b1, w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        // WIDTH=8 instance.
        issue8(OP_MUL, 16'd15, 16'd17, w);
        cnt  = 0;
        viol = 0;
        while (1) begin
            if (in_ready8) viol++;
            @(posedge clk);
            #1;
            cnt++;
            if (out_valid8 || cnt >= 40) break;
        end
        chk("w8_mul_latency", cnt, 8);
        chk("w8_mul_in_ready_low", viol, 0);
        issue8(OP_MUL, 16'd16, 16'd16, w);
        issue8(OP_SHIFT, 16'd1, 16'd7, w);
        repeat (100) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_opnd(8);
            if (o == OP_SHIFT && $urandom_range(0, 1) == 1) b = 16'(int'($urandom_range(0, 20)) - 10);
            else b = rnd_opnd(8);
            issue8(o, a, b, w);
        end

        cnt = 0;
        while ((q16.size() != 0 || q8.size() != 0) && cnt < 300) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        chk("drain_queues_empty", q16.size() + q8.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parameterised, handshaked successor to the single-cycle ALU. Accepts one operation per transaction over a valid/ready interface. Executes ADD/SUB/SLT/AND/OR/XOR/SHIFT in one cycle and MUL with an iterative shift-add engine. Holds each result, with status flags, in an output register until the consumer accepts it. Sits between the decode/issue stage and register writeback, so that a stalled writeback can no longer drop a result.

Parameters:
WIDTH, 16, operand/result width in bits; bit 0 is MSB (vectors declared [0:WIDTH-1]); minimum 4.
CNT_W, 5, width of the multiply step counter; must hold WIDTH (ceil(log2(WIDTH+1))).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
in_valid  in  1  operation offered this cycle
in_ready  out  1  block can accept an operation this cycle
op  in  3  opcode, `ALU_* encodings from parameters.vh
in1  in  WIDTH  operand A
in2  in  WIDTH  operand B
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer accepts result this cycle
out  out  WIDTH  result
zero  out  1  out == 0
carry  out  1  ADD carry-out / SUB borrow; 0 for other ops
overflow  out  1  signed overflow (ADD/SUB); high half non-zero (MUL, unsigned); 0 otherwise

Behaviour:
- Reset (async): state=IDLE, out_valid=0, out=0, zero=0, carry=0, overflow=0, counter=0, multiply accumulators=0. in_ready=1 once reset is deasserted. A reset during MUL_BUSY discards the operation; no result is produced.
- Accept: an input transfer occurs on a rising edge with in_valid && in_ready. op/in1/in2 are sampled only at accept.
- Consume: an output transfer occurs on a rising edge with out_valid && out_ready.
- States: IDLE (no result held), MUL_BUSY (iterating), FULL (result held).
- in_ready = (state==IDLE) || (state==FULL && out_ready). in_ready is 0 in MUL_BUSY. Back-to-back single-cycle ops therefore sustain 1 op/cycle while out_ready=1.
- Single-cycle ops: accepted at edge N; out/flags/out_valid=1 visible after edge N (latency 1). State -> FULL.
- MUL: accept loads multiplicand=in1, multiplier=in2, acc=0 (2*WIDTH bits), counter=WIDTH; state -> MUL_BUSY.
  - Each edge in MUL_BUSY: if the multiplier LSB is 1, add the multiplicand into acc; shift multiplicand left and multiplier right; decrement counter.
  - On the edge where counter goes 1->0: out=acc low WIDTH bits, overflow=|acc high half, carry=0, out_valid=1; state -> FULL.
  - Result is visible WIDTH edges after accept (16 for the default).
- FULL: out and flags stay stable until consume.
  - Consume without a new accept -> IDLE, out_valid=0. out keeps its last value.
  - Simultaneous consume and accept: the new op is accepted. A single-cycle op overwrites the register and stays FULL. A MUL goes to MUL_BUSY with out_valid=0.
- Arithmetic: ADD/SUB are modulo 2^WIDTH. carry = unsigned carry-out (ADD) or borrow, in1<in2 unsigned (SUB). overflow = two's-complement overflow.
- SLT: signed compare; out=1 if in1<in2, else 0. No flags other than zero.
- AND/OR/XOR: bitwise. carry=overflow=0.
- SHIFT: in2 is a signed shift amount. A positive amount shifts in1 left logical; a negative amount shifts right logical by |in2|. |in2| >= WIDTH gives 0. in2=0 passes in1.
- zero is computed from the value loaded into out and is registered together with it.
- in_valid while in_ready=0: ignored. The producer must hold its inputs.
- Unused opcode encodings (if any) produce out=0, flags 0, latency 1.

Test Plan:
- Single-cycle sweep, out_ready=1, one op/cycle (WIDTH=16): ADD 5+7=12, SUB 15-4=11, SLT 5<7=1, AND 9&12=8, OR 9|12=13, XOR 9^12=5, SHIFT 5,3=40 -> each result appears 1 cycle after accept, in_ready stays 1.
- Shift/flag edges: SHIFT 40,-3 -> 5. SHIFT 1,16 -> 0, zero=1. ADD 0xFFFF+1 -> 0, carry=1, zero=1. ADD 0x7FFF+1 -> 0x8000, overflow=1. SUB 4-15 -> 0xFFF5, carry=1. SLT 0xFFFF,1 -> 1.
- MUL latency: MUL 4*9 -> out_valid rises exactly 16 cycles after accept, out=36, overflow=0, in_ready=0 throughout. MUL 0x0100*0x0100 -> out=0, overflow=1, zero=1.
- Backpressure: hold out_ready=0 after ADD 5+7 -> out_valid=1 and out=12 stable for 10 cycles, in_ready=0, a second offered op is not accepted. Raise out_ready -> consume and accept occur on the same edge, and the next result follows 1 cycle later.
- Reset mid-operation: assert reset 5 cycles into MUL 4*9 -> out_valid=0 and out=0 immediately (asynchronously, before the next clock edge). After release, in_ready=1 and ADD 1+1 returns 2 with no stale MUL result.
- Parameter sweep: WIDTH=8 build (CNT_W=4). MUL 15*17 -> 255 after 8 cycles, overflow=0. MUL 16*16 -> 0, overflow=1. SHIFT 1,7 -> 0x80.
